oai211_vector_sequencer: RTL and testbench

- Self-test controller for one OAI211 cell instance (ZN = !((A1|A2)&B&C)).
- Drives all 16 input combinations onto the cell's A1/A2/B/C pins and waits a programmable settle time after each. Then samples ZN and compares it with the expected value.
- Sits beside the cell in the library characterization/silicon-debug harness. Reports pass/fail, error count and the first failing vector.

---
 rtl/oai211_seq_pkg.sv | 27 ++
 rtl/oai211_settle_timer.sv | 35 +++
 rtl/oai211_vector_sequencer.sv | 173 +++++++++++++++++
 tb/tb_oai211_vector_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oai211_seq_pkg.sv
// ---------------------------------------------------------------------------
// oai211_seq_pkg
// Shared definitions for the OAI211 vector sequencer.
//   - seq_state_t   : sequencer FSM states (3-bit encoding)
//   - OAI211_EXP_TT : expected ZN for vector index v (bit v)
//   - PIN_*         : bit positions of each cell pin within the vector index
// Optional feature macro used by the sequencer: OAI211_VECTOR_SEQUENCER_LOOP_EN
// ---------------------------------------------------------------------------
package oai211_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_t;

  // ZN = !((A1|A2)&B&C); zero only for v = 7, 11, 15
  localparam logic [15:0] OAI211_EXP_TT = 16'h777F;

  localparam int PIN_A1 = 3;
  localparam int PIN_A2 = 2;
  localparam int PIN_B  = 1;
  localparam int PIN_C  = 0;

endpackage

// File: rtl/oai211_settle_timer.sv
// ---------------------------------------------------------------------------
// oai211_settle_timer
// Loadable 4-bit down-counter that times the settle window after a vector
// has been applied to the cell.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   load       : load settle_cyc into the counter on this edge
//   settle_cyc : settle length in cycles (1..15 when used)
//   expire     : high during the last settle cycle (counter == 1)
// ---------------------------------------------------------------------------
module oai211_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] settle_cyc,
  output logic       expire
);

  logic [3:0] count;

  // Counter parks at zero once drained so expire fires only once per load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= settle_cyc;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign expire = (count == 4'd1);

endmodule

// File: rtl/oai211_vector_sequencer.sv
// ---------------------------------------------------------------------------
// oai211_vector_sequencer
// Self-test controller for one OAI211 cell. Sweeps all 16 input vectors onto
// A1/A2/B/C, waits SETTLE_CYC cycles, samples ZN and compares against the
// expected truth table. Reports pass/fail, a saturating error count and the
// first failing vector.
// Parameters:
//   SETTLE_CYC : idle cycles between applying a vector and sampling (0..15)
//   NUM_PASSES : full sweeps per START (1..255)
//   ERR_W      : width of the saturating error counter
// Ports:
//   CLK, RN          : clock, asynchronous active-low reset
//   START, ABORT     : sweep start pulse, synchronous abort (ABORT wins)
//   ZN               : cell output under test
//   A1, A2, B, C     : registered drive to the cell
//   BUSY, DONE, PASS : status (PASS valid while DONE)
//   ERR_CNT          : mismatch count, saturating
//   FAIL_VEC         : index of the first mismatching vector
//   FAIL_SEEN        : set on the first mismatch
// Optional feature: define OAI211_VECTOR_SEQUENCER_LOOP_EN to sweep forever
// until ABORT; DONE never asserts and PASS tracks ERR_CNT==0 while busy.
// ---------------------------------------------------------------------------
module oai211_vector_sequencer
  import oai211_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int NUM_PASSES = 1,
  parameter int ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ABORT,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             B,
  output logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [3:0]       FAIL_VEC,
  output logic             FAIL_SEEN
);

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYC);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

`ifndef OAI211_VECTOR_SEQUENCER_LOOP_EN
  localparam logic [7:0] LAST_PASS = 8'(NUM_PASSES - 1);
  logic [7:0] pass_cnt;
`endif

  seq_state_t state;
  logic [3:0] vec;
  logic [3:0] drive;
  logic       active;
  logic       mismatch;
  logic       settle_load;
  logic       settle_expire;

  assign active      = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign mismatch    = (ZN != OAI211_EXP_TT[vec]);
  assign settle_load = (state == ST_APPLY);

  assign A1 = drive[PIN_A1];
  assign A2 = drive[PIN_A2];
  assign B  = drive[PIN_B];
  assign C  = drive[PIN_C];

  oai211_settle_timer u_settle_timer (
    .clk        (CLK),
    .rst_n      (RN),
    .load       (settle_load),
    .settle_cyc (SETTLE_LD),
    .expire     (settle_expire)
  );

  // Main FSM. BUSY/DONE/PASS are registered from the current state, so they
  // trail the state by one edge; START and ABORT override them directly so
  // that clearing is visible right after the accepting edge.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state     <= ST_IDLE;
      vec       <= 4'd0;
      drive     <= 4'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= '0;
      FAIL_VEC  <= 4'd0;
      FAIL_SEEN <= 1'b0;
`ifndef OAI211_VECTOR_SEQUENCER_LOOP_EN
      pass_cnt  <= 8'd0;
`endif
    end else if (ABORT) begin
      // Error history is kept for debug; only the sweep itself is dropped.
      state <= ST_IDLE;
      drive <= 4'd0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      BUSY <= active;
`ifdef OAI211_VECTOR_SEQUENCER_LOOP_EN
      DONE <= 1'b0;
      PASS <= active && (ERR_CNT == '0);
`else
      DONE <= (state == ST_DONE);
      PASS <= (state == ST_DONE) && (ERR_CNT == '0);
`endif
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            ERR_CNT   <= '0;
            FAIL_VEC  <= 4'd0;
            FAIL_SEEN <= 1'b0;
            PASS      <= 1'b0;
            DONE      <= 1'b0;
            vec       <= 4'd0;
            drive     <= 4'd0;
`ifndef OAI211_VECTOR_SEQUENCER_LOOP_EN
            pass_cnt  <= 8'd0;
`endif
            state     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          state <= (SETTLE_LD != 4'd0) ? ST_SETTLE : ST_SAMPLE;
        end
        ST_SETTLE: begin
          if (settle_expire) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            if (ERR_CNT != '1) begin
              ERR_CNT <= ERR_CNT + ERR_ONE;
            end
            if (!FAIL_SEEN) begin
              FAIL_SEEN <= 1'b1;
              FAIL_VEC  <= vec;
            end
          end
          // The next vector is driven on the same edge that enters APPLY.
          if (vec != 4'd15) begin
            vec   <= vec + 4'd1;
            drive <= vec + 4'd1;
            state <= ST_APPLY;
`ifdef OAI211_VECTOR_SEQUENCER_LOOP_EN
          end else begin
            vec   <= 4'd0;
            drive <= 4'd0;
            state <= ST_APPLY;
          end
`else
          end else if (pass_cnt < LAST_PASS) begin
            vec      <= 4'd0;
            drive    <= 4'd0;
            pass_cnt <= pass_cnt + 8'd1;
            state    <= ST_APPLY;
          end else begin
            state <= ST_DONE;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oai211_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_oai211_vector_sequencer
// Three sequencer instances with different parameters, each driving its own
// behavioural OAI211 cell model whose fault mode the bench selects:
//   dut0 : SETTLE_CYC=2, NUM_PASSES=1, ERR_W=8
//   dut1 : SETTLE_CYC=2, NUM_PASSES=2, ERR_W=4
//   dut2 : SETTLE_CYC=0, NUM_PASSES=1, ERR_W=8
// Expected results are computed from the cell equation and queued when a
// sweep is started, then popped when the DUT reports completion.
// ---------------------------------------------------------------------------
module tb_oai211_vector_sequencer;

  typedef struct {
    int done_edge;
    int pass;
    int err;
    int fail_vec;
    int fail_seen;
  } result_t;

  logic clk;
  logic rn;
  logic start [3];
  logic abort [3];
  int   fault_mode [3];

  wire       zn [3];
  wire       a1 [3];
  wire       a2 [3];
  wire       b [3];
  wire       c [3];
  wire       busy [3];
  wire       done [3];
  wire       pass [3];
  wire       fail_seen [3];
  wire [3:0] fail_vec [3];
  wire [7:0] err_cnt [3];
  wire [3:0] err_narrow;

  result_t sb [$];
  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cell: ZN = !((A1|A2)&B&C)
  function automatic logic good_zn(input logic [3:0] v);
    return ~((v[3] | v[2]) & v[1] & v[0]);
  endfunction

  // Cell under test: 0 good, 1 stuck-at-1, 2 stuck-at-0, 3 wrong at vector 3
  function automatic logic model_zn(input int mode, input logic [3:0] v);
    case (mode)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (v == 4'd3) ? ~good_zn(v) : good_zn(v);
      default: return good_zn(v);
    endcase
  endfunction

  assign zn[0] = model_zn(fault_mode[0], {a1[0], a2[0], b[0], c[0]});
  assign zn[1] = model_zn(fault_mode[1], {a1[1], a2[1], b[1], c[1]});
  assign zn[2] = model_zn(fault_mode[2], {a1[2], a2[2], b[2], c[2]});
  assign err_cnt[1] = {4'b0000, err_narrow};

  oai211_vector_sequencer #(.SETTLE_CYC(2), .NUM_PASSES(1), .ERR_W(8)) dut0 (
    .CLK(clk), .RN(rn), .START(start[0]), .ABORT(abort[0]), .ZN(zn[0]),
    .A1(a1[0]), .A2(a2[0]), .B(b[0]), .C(c[0]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
    .ERR_CNT(err_cnt[0]), .FAIL_VEC(fail_vec[0]), .FAIL_SEEN(fail_seen[0])
  );

  oai211_vector_sequencer #(.SETTLE_CYC(2), .NUM_PASSES(2), .ERR_W(4)) dut1 (
    .CLK(clk), .RN(rn), .START(start[1]), .ABORT(abort[1]), .ZN(zn[1]),
    .A1(a1[1]), .A2(a2[1]), .B(b[1]), .C(c[1]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
    .ERR_CNT(err_narrow), .FAIL_VEC(fail_vec[1]), .FAIL_SEEN(fail_seen[1])
  );

  oai211_vector_sequencer #(.SETTLE_CYC(0), .NUM_PASSES(1), .ERR_W(8)) dut2 (
    .CLK(clk), .RN(rn), .START(start[2]), .ABORT(abort[2]), .ZN(zn[2]),
    .A1(a1[2]), .A2(a2[2]), .B(b[2]), .C(c[2]),
    .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]),
    .ERR_CNT(err_cnt[2]), .FAIL_VEC(fail_vec[2]), .FAIL_SEEN(fail_seen[2])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int pins_of(input int idx);
    return int'({a1[idx], a2[idx], b[idx], c[idx]});
  endfunction

  function automatic int all_outputs(input int idx);
    return int'({a1[idx], a2[idx], b[idx], c[idx], busy[idx], done[idx], pass[idx],
                 fail_seen[idx], fail_vec[idx], err_cnt[idx]});
  endfunction

  task automatic pulseStart(input int idx);
    @(negedge clk);
    start[idx] = 1'b1;
    @(posedge clk);
    #1;
    start[idx] = 1'b0;
  endtask

  // Queue the expected result for the first n_vec sampled vectors, then
  // pulse START (sampled at edge 0).
  task automatic applyStimulus(input int idx, input int settle, input int passes,
                               input int n_vec, input int err_max);
    result_t r;
    r.err = 0;
    r.fail_seen = 0;
    r.fail_vec = 0;
    for (int i = 0; i < n_vec; i++) begin
      logic [3:0] v;
      v = 4'(i % 16);
      if (model_zn(fault_mode[idx], v) != good_zn(v)) begin
        if (r.err < err_max) r.err++;
        if (r.fail_seen == 0) begin
          r.fail_seen = 1;
          r.fail_vec = int'(v);
        end
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    r.done_edge = 1 + 16 * passes * (settle + 2);
    sb.push_back(r);
    pulseStart(idx);
  endtask

  task automatic runSweep(input string name, input int idx, input int settle,
                          input int passes, input int err_max);
    result_t exp_r;
    int total;
    int seen_edge;
    total = 16 * passes * (settle + 2);
    seen_edge = -1;
    applyStimulus(idx, settle, passes, 16 * passes, err_max);
    for (int k = 1; k <= total + 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) checkOutput({name, "_busy_high"}, int'(busy[idx]), 1);
      if (k < total) checkOutput({name, "_pins"}, pins_of(idx), (k / (settle + 2)) % 16);
      if (done[idx] === 1'b1) begin
        seen_edge = k;
        break;
      end
    end
    exp_r = sb.pop_front();
    checkOutput({name, "_done_edge"}, seen_edge, exp_r.done_edge);
    checkOutput({name, "_pass"}, int'(pass[idx]), exp_r.pass);
    checkOutput({name, "_err_cnt"}, int'(err_cnt[idx]), exp_r.err);
    checkOutput({name, "_fail_vec"}, int'(fail_vec[idx]), exp_r.fail_vec);
    checkOutput({name, "_fail_seen"}, int'(fail_seen[idx]), exp_r.fail_seen);
    checkOutput({name, "_busy_low"}, int'(busy[idx]), 0);
    checkOutput({name, "_last_vec"}, pins_of(idx), 15);
  endtask

  initial begin
    result_t exp_r;
    int k;
    n_checks = 0;
    n_fail = 0;
    rn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      fault_mode[i] = 0;
    end

    #12;
    for (int i = 0; i < 3; i++) checkOutput("reset_outputs", all_outputs(i), 0);
    @(negedge clk);
    rn = 1'b1;

    $display("[TB] good cell, SETTLE_CYC=2");
    runSweep("good", 0, 2, 1, 255);

    $display("[TB] stuck-at-1 cell");
    fault_mode[0] = 1;
    runSweep("sa1", 0, 2, 1, 255);

    $display("[TB] stuck-at-0 cell, two passes, 4-bit counter");
    fault_mode[1] = 2;
    runSweep("sa0", 1, 2, 2, 15);

    $display("[TB] good cell, SETTLE_CYC=0");
    runSweep("nosettle", 2, 0, 1, 255);

    $display("[TB] abort at vector 5 with fault at vector 3");
    fault_mode[0] = 3;
    applyStimulus(0, 2, 1, 5, 255);
    for (k = 1; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (pins_of(0) == 5) break;
    end
    checkOutput("abort_reach_vec5", pins_of(0), 5);
    @(negedge clk);
    abort[0] = 1'b1;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    abort[0] = 1'b0;
    start[0] = 1'b0;
    exp_r = sb.pop_front();
    checkOutput("abort_busy", int'(busy[0]), 0);
    checkOutput("abort_done", int'(done[0]), 0);
    checkOutput("abort_pins", pins_of(0), 0);
    checkOutput("abort_err_cnt", int'(err_cnt[0]), exp_r.err);
    checkOutput("abort_fail_vec", int'(fail_vec[0]), exp_r.fail_vec);
    checkOutput("abort_fail_seen", int'(fail_seen[0]), exp_r.fail_seen);
    @(posedge clk);
    #1;
    checkOutput("abort_start_ignored", int'(busy[0]), 0);

    $display("[TB] reset during settle");
    fault_mode[0] = 2;
    pulseStart(0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", int'(busy[0]), 1);
    checkOutput("pre_reset_err_cnt", int'(err_cnt[0]), 2);
    #2;
    rn = 1'b0;
    #1;
    checkOutput("async_reset_outputs", all_outputs(0), 0);
    @(negedge clk);
    rn = 1'b1;
    fault_mode[0] = 0;
    runSweep("post_reset", 0, 2, 1, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got %0d, expected %0d", 1, 0);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
